// File: rtl/ssd_scan_ctrl_if.sv
// Display-side bus for the seven-segment scan controller: control/data in, anode/segment drive out.
interface ssd_scan_ctrl_if;
   logic        enable;
   logic [15:0] value;
   logic        load;
   logic        blank_lz;
   logic [3:0]  an;
   logic [6:0]  seg;
   logic        frame_done;

   modport master (
      output enable, value, load, blank_lz,
      input  an, seg, frame_done
   );

   modport slave (
      input  enable, value, load, blank_lz,
      output an, seg, frame_done
   );
endinterface

// File: rtl/ssd_scan_ctrl.sv
// Time-multiplexed 4-digit common-anode seven-segment scanner with guard time,
// frame-boundary value commit and optional leading-zero blanking.
//
// state | meaning
// DIG0  | scanning digit 0 (value[3:0], rightmost)
// DIG1  | scanning digit 1
// DIG2  | scanning digit 2
// DIG3  | scanning digit 3; terminal count here is the frame wrap
module ssd_scan_ctrl #(
   parameter int REFRESH_DIV = 100000,
   parameter int GUARD       = 2
) (
   input  logic           clk,
   input  logic           reset,
   ssd_scan_ctrl_if.slave bus
);

   localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam logic [PW-1:0] PRESC_TC = PW'(REFRESH_DIV - 1);

   typedef enum logic [1:0] {DIG0, DIG1, DIG2, DIG3} digit_e;

   digit_e        idx_q, idx_d;
   logic [PW-1:0] presc_q, presc_d;
   logic [15:0]   disp_q, disp_d;
   logic [15:0]   pend_q, pend_d;
   logic          pend_valid_q, pend_valid_d;
   logic [3:0]    an_q, an_d;
   logic [6:0]    seg_q, seg_d;
   logic          frame_done_q, frame_done_d;

   logic          tc, wrap, guard_on, digit_lz;
   logic [3:0]    nib, an_sel;

   function automatic logic [6:0] hex_to_seg(input logic [3:0] h);
      logic [6:0] s;
      case (h)
         4'h0: s = 7'b1000000;
         4'h1: s = 7'b1111001;
         4'h2: s = 7'b0100100;
         4'h3: s = 7'b0110000;
         4'h4: s = 7'b0011001;
         4'h5: s = 7'b0010010;
         4'h6: s = 7'b0000010;
         4'h7: s = 7'b1111000;
         4'h8: s = 7'b0000000;
         4'h9: s = 7'b0010000;
         4'hA: s = 7'b0001000;
         4'hB: s = 7'b0000011;
         4'hC: s = 7'b1000110;
         4'hD: s = 7'b0100001;
         4'hE: s = 7'b0000110;
         default: s = 7'b0001110;
      endcase
      return s;
   endfunction

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         idx_q        <= DIG0;
         presc_q      <= '0;
         disp_q       <= '0;
         pend_q       <= '0;
         pend_valid_q <= 1'b0;
         an_q         <= 4'b1111;
         seg_q        <= 7'b1111111;
         frame_done_q <= 1'b0;
      end else begin
         idx_q        <= idx_d;
         presc_q      <= presc_d;
         disp_q       <= disp_d;
         pend_q       <= pend_d;
         pend_valid_q <= pend_valid_d;
         an_q         <= an_d;
         seg_q        <= seg_d;
         frame_done_q <= frame_done_d;
      end
   end

   always_comb begin
      tc       = (presc_q == PRESC_TC);
      wrap     = bus.enable && tc && (idx_q == DIG3);
      guard_on = (32'(presc_q) < 32'(GUARD));

      presc_d = presc_q;
      idx_d   = idx_q;
      if (bus.enable) begin
         if (tc) begin
            presc_d = '0;
            case (idx_q)
               DIG0:    idx_d = DIG1;
               DIG1:    idx_d = DIG2;
               DIG2:    idx_d = DIG3;
               default: idx_d = DIG0;
            endcase
         end else begin
            presc_d = presc_q + 1'b1;
         end
      end

      // A digit is a leading zero when it and every digit to its left are zero.
      case (idx_q)
         DIG0: begin nib = disp_q[3:0];   an_sel = 4'b1110; digit_lz = 1'b0; end
         DIG1: begin nib = disp_q[7:4];   an_sel = 4'b1101; digit_lz = (disp_q[15:4] == 12'h000); end
         DIG2: begin nib = disp_q[11:8];  an_sel = 4'b1011; digit_lz = (disp_q[15:8] == 8'h00); end
         default: begin nib = disp_q[15:12]; an_sel = 4'b0111; digit_lz = (disp_q[15:12] == 4'h0); end
      endcase

      an_d         = 4'b1111;
      seg_d        = 7'b1111111;
      frame_done_d = 1'b0;
      if (bus.enable) begin
         frame_done_d = wrap;
         if (!guard_on) begin
            an_d = an_sel;
            if (!(bus.blank_lz && digit_lz)) seg_d = hex_to_seg(nib);
         end
      end

      // While dark there is no frame boundary to wait for, so loads commit at once.
      disp_d       = disp_q;
      pend_d       = pend_q;
      pend_valid_d = pend_valid_q;
      if (!bus.enable && bus.load) begin
         disp_d       = bus.value;
         pend_d       = bus.value;
         pend_valid_d = 1'b0;
      end else begin
         if (wrap && pend_valid_q) begin
            disp_d       = pend_q;
            pend_valid_d = 1'b0;
         end
         if (bus.load) begin
            pend_d       = bus.value;
            pend_valid_d = 1'b1;
         end
      end
   end

   assign bus.an         = an_q;
   assign bus.seg        = seg_q;
   assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_ssd_scan_ctrl.sv
// Directed plus randomized bench for ssd_scan_ctrl against a slot-position reference model.
module tb_ssd_scan_ctrl;
   localparam int R = 4;
   localparam int G = 1;

   logic clk = 1'b0;
   logic reset = 1'b0;
   always #5 clk = ~clk;

   ssd_scan_ctrl_if bus ();

   ssd_scan_ctrl #(.REFRESH_DIV(R), .GUARD(G)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int n_chk  = 0;
   int n_fail = 0;

   // Model: position within the 4*R-cycle frame, shown value, pending value.
   int          m_pos;
   logic [15:0] m_disp, m_pend;
   bit          m_pv;

   logic [6:0] seg_tab [16] = '{
      7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
      7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
      7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
      7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
   };

   task automatic chk3(input string tag, input logic [3:0] ea, input logic [6:0] es, input logic ef);
      n_chk++;
      assert (bus.an === ea) else begin
         n_fail++;
         $error("FAIL %s an got %b want %b (pos %0d)", tag, bus.an, ea, m_pos);
      end
      n_chk++;
      assert (bus.seg === es) else begin
         n_fail++;
         $error("FAIL %s seg got %b want %b (pos %0d)", tag, bus.seg, es, m_pos);
      end
      n_chk++;
      assert (bus.frame_done === ef) else begin
         n_fail++;
         $error("FAIL %s frame_done got %b want %b (pos %0d)", tag, bus.frame_done, ef, m_pos);
      end
   endtask

   task automatic model_reset();
      m_pos  = 0;
      m_disp = 16'h0000;
      m_pend = 16'h0000;
      m_pv   = 1'b0;
   endtask

   task automatic cyc(input string tag);
      logic [3:0]  ea = 4'b1111;
      logic [6:0]  es = 7'b1111111;
      logic        ef = 1'b0;
      bit          en, ld, blz, last;
      logic [15:0] val, n_disp, n_pend;
      bit          n_pv;
      int          d, p, n_pos, nibv;
      en   = bus.enable;
      ld   = bus.load;
      blz  = bus.blank_lz;
      val  = bus.value;
      d    = m_pos / R;
      p    = m_pos % R;
      last = (m_pos == 4*R - 1);
      if (en) begin
         ef = last;
         if (p >= G) begin
            ea   = ~(4'(1) << d);
            nibv = int'((m_disp >> (4*d)) & 16'h000F);
            if (blz && d >= 1 && (m_disp >> (4*d)) == 16'h0000) es = 7'b1111111;
            else es = seg_tab[nibv];
         end
      end
      n_pos  = en ? (m_pos + 1) % (4*R) : m_pos;
      n_disp = m_disp;
      n_pend = m_pend;
      n_pv   = m_pv;
      if (!en && ld) begin
         n_disp = val;
         n_pv   = 1'b0;
      end else begin
         if (en && last && m_pv) begin
            n_disp = m_pend;
            n_pv   = 1'b0;
         end
         if (ld) begin
            n_pend = val;
            n_pv   = 1'b1;
         end
      end
      @(posedge clk);
      #1;
      chk3(tag, ea, es, ef);
      m_pos  = n_pos;
      m_disp = n_disp;
      m_pend = n_pend;
      m_pv   = n_pv;
   endtask

   task automatic load_val(input string tag, input logic [15:0] v);
      bus.value = v;
      bus.load  = 1'b1;
      cyc(tag);
      bus.load  = 1'b0;
   endtask

   task automatic run_to(input string tag, input int target);
      for (int k = 0; k < 4*R + 1; k++) begin
         if (m_pos == target) break;
         cyc(tag);
      end
   endtask

   initial begin
      bus.enable   = 1'b0;
      bus.load     = 1'b0;
      bus.value    = 16'h0000;
      bus.blank_lz = 1'b0;
      model_reset();

      #1 reset = 1'b1;
      #1 chk3("reset", 4'b1111, 7'b1111111, 1'b0);
      @(negedge clk);
      reset = 1'b0;

      // Basic scan of 12AF.
      bus.enable = 1'b1;
      load_val("t1_load", 16'h12AF);
      repeat (40) cyc("t1_scan");

      // New value mid-digit-2 waits for the frame boundary.
      run_to("t2_seek", 2*R + 1);
      load_val("t2_load", 16'h3456);
      repeat (40) cyc("t2_scan");

      // Leading-zero blanking.
      bus.blank_lz = 1'b1;
      load_val("t3_load7", 16'h0007);
      repeat (36) cyc("t3_0007");
      load_val("t3_load0", 16'h0000);
      repeat (36) cyc("t3_0000");
      load_val("t3_load100", 16'h0100);
      repeat (36) cyc("t3_0100");
      bus.blank_lz = 1'b0;

      // Load coinciding with the wrap.
      run_to("t4_seek", 3);
      load_val("t4_first", 16'hAAAA);
      run_to("t4_seek2", 4*R - 1);
      load_val("t4_onwrap", 16'h5B5B);
      repeat (40) cyc("t4_scan");

      // Disable mid-slot, load while dark, resume.
      run_to("t5_seek", 6);
      bus.enable = 1'b0;
      repeat (3) cyc("t5_dark");
      load_val("t5_beef", 16'hBEEF);
      repeat (2) cyc("t5_dark2");
      bus.enable = 1'b1;
      repeat (24) cyc("t5_resume");

      // Async reset mid-frame discards the pending value.
      run_to("t6_seek", 2);
      load_val("t6_load", 16'hC0DE);
      run_to("t6_seek2", 5);
      #3 reset = 1'b1;
      #1 chk3("t6_async_rst", 4'b1111, 7'b1111111, 1'b0);
      model_reset();
      @(negedge clk);
      reset = 1'b0;
      repeat (36) cyc("t6_after");

      // Randomized traffic.
      for (int i = 0; i < 400; i++) begin
         bus.enable = ($urandom_range(0, 9) != 0);
         bus.load   = ($urandom_range(0, 7) == 0);
         bus.value  = 16'($urandom);
         if ($urandom_range(0, 31) == 0) bus.blank_lz = ~bus.blank_lz;
         cyc("rand");
      end
      bus.load = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/ssd_scan_ctrl.md
Name: ssd_scan_ctrl

Overview:
Time-multiplexed scan controller for the board's 4-digit, common-anode seven-segment display. It latches a 16-bit value, steps through the digits at a programmable refresh rate, and drives active-low anodes and hex segment codes. It also inserts anti-ghosting guard time at each digit change and commits new values only at frame boundaries, so a display never shows a mix of old and new digits. It sits between the pipeline's debug/readout mux and the board I/O pins.

Parameters:
REFRESH_DIV, 100000, clk cycles per digit slot (legal range ≥ GUARD+2).
GUARD, 2, cycles at the start of each slot with all anodes off (legal range 0 to REFRESH_DIV-2).

Ports:
clk  input  1  system clock.
reset  input  1  asynchronous, active-high reset.
enable  input  1  1 = scanning; 0 = display dark, counters held.
value  input  16  hex value to display; digit0 = value[3:0] (rightmost), digit3 = value[15:12].
load  input  1  single-cycle strobe; captures value into the pending register.
blank_lz  input  1  1 = blank leading zero digits.
an  output  4  active-low anode select; an[i] drives digit i.
seg  output  7  active-low segments {g,f,e,d,c,b,a}.
frame_done  output  1  one-cycle pulse at each 3→0 digit wrap.

Behaviour:
- Reset (async, immediate): an=4'b1111, seg=7'b1111111, frame_done=0, prescaler=0, idx=0, disp_reg=16'h0000, pending=16'h0000, pend_valid=0.
- Prescaler counts 0..REFRESH_DIV-1 while enable=1. At the terminal count it wraps to 0 and idx advances 0→1→2→3→0.
- Wrap event: terminal count with idx=3.
  - frame_done=1 for the next cycle only.
  - If pend_valid=1: disp_reg<=pending and pend_valid<=0.
- Load (rising clk with load=1): pending<=value and pend_valid<=1. With several loads before a wrap, the last one wins.
- Load coinciding with a wrap: disp_reg takes the old pending; the new value goes to pending; pend_valid stays 1.
- Load with enable=0: value commits directly to disp_reg on the same edge; pend_valid<=0.
- Outputs an, seg and frame_done are registered. They reflect prescaler/idx/disp_reg with 1-cycle latency.
- Guard: while prescaler < GUARD, an=4'b1111 and seg=7'b1111111. Otherwise an = ~(4'b0001<<idx) and seg = decode(nibble idx).
- Decode, hex 0..F in order, seg =
  - 0–3: 1000000, 1111001, 0100100, 0110000
  - 4–7: 0011001, 0010010, 0000010, 1111000
  - 8–B: 0000000, 0010000, 0001000, 0000011
  - C–F: 1000110, 0100001, 0000110, 0001110
- Leading-zero blanking: if blank_lz=1, digit i (i≥1) is blanked (seg=1111111, anode still asserted) when digits i..3 of disp_reg are all zero. Digit 0 is never blanked, so 0x0000 shows "0".
- enable 1→0: next cycle an=4'b1111 and seg=7'b1111111. Prescaler and idx hold their values; frame_done=0.
- enable 0→1: scanning resumes from the held prescaler/idx.
- Reset mid-slot or mid-frame: all state clears immediately; any pending value is discarded.

Test Plan:
1. REFRESH_DIV=4, GUARD=1; load 16'h12AF, enable=1, blank_lz=0 → per slot an=1111 for 1 cycle, then an=1110/seg=0001110 (F), 1101/0001000 (A), 1011/0100100 (2), 0111/1111001 (1). frame_done pulses once per 16 cycles.
2. During frame showing 12AF, load 16'h3456 mid-digit-2 → remaining digits of the current frame still show 12AF; the frame after frame_done shows 3,4,5,6.
3. blank_lz=1, load 16'h0007 → digits 3..1 seg=1111111, digit 0 seg=1111000. Then load 16'h0000 → digit 0 shows 1000000, others blank. Then load 16'h0100 → digit 3 blank; digits 2,1,0 show 1,0,0.
4. Load exactly on the wrap cycle → previous pending is displayed that frame; the new value appears one frame later; no value is lost.
5. Drop enable mid-slot → an=1111 within 1 cycle, frame_done stays 0. Load 16'hBEEF while disabled, re-enable → scan resumes at the held idx showing BEEF immediately.
6. Assert reset asynchronously between clock edges mid-frame with pend_valid=1 → an=1111, seg=1111111 before the next edge. After release, 0000 is displayed and the pending value is discarded.
